// File: rtl/count_step_ctrl.sv
// count_step_ctrl: run/step enable source; STEP_AUTOREPEAT_EN adds held-button auto-repeat
module count_step_ctrl #(
  parameter int TICK_DIV        = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_sw,
  input  logic       step_btn,
  output logic       enable,
  output logic       running,
  output logic [1:0] step_state
);
  localparam int DW = $clog2(TICK_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  // the IDLE/HELD cycle that spots the new level counts as the first stable sample
  localparam logic [BW-1:0] DB_LAST = BW'(DEBOUNCE_CYCLES - 2);
  typedef enum logic [1:0] {IDLE = 2'b00, PRESS_WAIT = 2'b01, HELD = 2'b10, RELEASE_WAIT = 2'b11} state_t;
  if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("count_step_ctrl: TICK_DIV, DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end
  state_t        state;
  logic          run_m, run_s, btn_m, btn_s;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] db_cnt;
  logic          tick, press_done, rep_fire, step;
  assign running    = run_s;
  assign step_state = state;
  assign tick       = div_cnt == DIV_LAST;
  assign press_done = state == PRESS_WAIT && btn_s && db_cnt == DB_LAST;
  assign step       = press_done || rep_fire;
  always_ff @(posedge clk) begin
    if (reset) begin
      run_m   <= 1'b0;
      run_s   <= 1'b0;
      btn_m   <= 1'b0;
      btn_s   <= 1'b0;
      div_cnt <= '0;
      db_cnt  <= '0;
      enable  <= 1'b0;
      state   <= IDLE;
    end else begin
      run_m   <= run_sw;
      run_s   <= run_m;
      btn_m   <= step_btn;
      btn_s   <= btn_m;
      div_cnt <= (!run_s || tick) ? '0 : div_cnt + 1'b1;
      enable  <= !enable && (run_s ? tick : step);
      case (state)
        IDLE:
          if (btn_s) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        PRESS_WAIT:
          if (!btn_s) state <= IDLE;
          else if (db_cnt == DB_LAST) state <= HELD;
          else db_cnt <= db_cnt + 1'b1;
        HELD:
          if (!btn_s) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
        RELEASE_WAIT:
          if (btn_s) state <= HELD;
          else if (db_cnt == DB_LAST) state <= IDLE;
          else db_cnt <= db_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef STEP_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt;
  assign rep_fire = state == HELD && !run_s && rep_cnt == REP_LAST;
  always_ff @(posedge clk) begin
    if (reset || state != HELD || run_s) rep_cnt <= '0;
    else rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif
endmodule

// File: tb/tb_count_step_ctrl.sv
// tb_count_step_ctrl: directed checks of tick, debounce, bounce, reset-abort and auto-repeat
module tb_count_step_ctrl;
  logic       clk = 1'b0, reset = 1'b1, run_sw = 1'b0, step_btn = 1'b0;
  logic       enable, running;
  logic [1:0] step_state;
  int n_cmp = 0, n_bad = 0, idx = 0;
  logic [63:0] en_v, run_v, exp_v;
  logic [15:0] seq;
  logic [1:0]  last_st;

  count_step_ctrl #(.TICK_DIV(8), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
    .enable(enable), .running(running), .step_state(step_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    idx = 0; en_v = '0; run_v = '0; seq = '0; last_st = step_state;
  endtask

  // bit i of en_v/run_v holds the output just after the i-th edge since clr
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      idx++;
      en_v[idx] = enable;
      run_v[idx] = running;
      if (step_state !== last_st) begin
        seq = {seq[13:0], step_state};
        last_st = step_state;
      end
    end
  endtask

  initial begin
    clr();
    run(3);
    check("rst_enable", 64'(enable), 0);
    check("rst_running", 64'(running), 0);
    check("rst_state", 64'(step_state), 0);
    reset = 1'b0;
    clr(); run(50);
    check("idle_no_pulse", en_v, 0);

    clr(); run_sw = 1'b1; run(40);
    exp_v = '0; for (int i = 2; i <= 40; i++) exp_v[i] = 1'b1;
    check("run_sync", run_v, exp_v);
    exp_v = '0; exp_v[10] = 1; exp_v[18] = 1; exp_v[26] = 1; exp_v[34] = 1;
    check("tick_pattern", en_v, exp_v);
    check("tick_b2b", en_v & (en_v << 1), 0);
    run_sw = 1'b0; run(10);

    clr(); step_btn = 1'b1; run(20); step_btn = 1'b0; run(15);
    exp_v = '0; exp_v[6] = 1;
`ifdef STEP_AUTOREPEAT_EN
    exp_v[16] = 1;
`endif
    check("press_pulse", en_v, exp_v);
    check("press_seq", 64'(seq), 64'h006C);
    check("press_b2b", en_v & (en_v << 1), 0);

    clr();
    step_btn = 1'b1; run(2); step_btn = 1'b0; run(1); step_btn = 1'b1; run(2); step_btn = 1'b0; run(15);
    check("bounce_no_pulse", en_v, 0);
    check("bounce_seq", 64'(seq), 64'h0044);
    check("bounce_state", 64'(step_state), 0);

    clr(); run_sw = 1'b1; step_btn = 1'b1; run(20);
    check("runmode_held", 64'(step_state), 2);
    run_sw = 1'b0; step_btn = 1'b0; run(15);
    exp_v = '0; exp_v[10] = 1; exp_v[18] = 1;
    check("runmode_tick_only", en_v, exp_v);
    check("runmode_idle", 64'(step_state), 0);

    clr(); step_btn = 1'b1; run(3);
    check("pw_before_rst", 64'(step_state), 1);
    reset = 1'b1; run(1);
    check("rst_abort_state", 64'(step_state), 0);
    run(2); reset = 1'b0;
    check("rst_abort_no_pulse", en_v, 0);
    clr(); run(15);
    exp_v = '0; exp_v[6] = 1;
    check("post_rst_pulse", en_v, exp_v);

    step_btn = 1'b0; run(15);
    clr(); step_btn = 1'b1; run(40); step_btn = 1'b0; run(15);
    exp_v = '0; exp_v[6] = 1;
`ifdef STEP_AUTOREPEAT_EN
    exp_v[16] = 1; exp_v[26] = 1; exp_v[36] = 1;
`endif
    check("hold_pulses", en_v, exp_v);
    check("hold_end_state", 64'(step_state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
